// File: rtl/spi_sched_pkg.sv
// -----------------------------------------------------------------------------
// spi_sched_pkg
// Shared definitions for the SPI transaction sequencer:
//   - SPI master register map (STATUS, DATA_OUT, DATA_IN, CTRL)
//   - CTRL / STATUS bit positions
//   - sequencer state encoding
//   - helper to build the CTRL byte
// -----------------------------------------------------------------------------
package spi_sched_pkg;

    // SPI master register addresses
    localparam logic [3:0] ADDR_STATUS   = 4'd0;
    localparam logic [3:0] ADDR_DATA_OUT = 4'd1;
    localparam logic [3:0] ADDR_DATA_IN  = 4'd2;
    localparam logic [3:0] ADDR_CTRL     = 4'd3;

    // CTRL: MODE in [1:0], slave select in [2]
    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_SS_BIT   = 2;

    // STATUS: shift-in-progress flag
    localparam int STATUS_BUSY_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SEL     = 4'd1,
        ST_WAIT_TX = 4'd2,
        ST_WR      = 4'd3,
        ST_POLL    = 4'd4,
        ST_CHK     = 4'd5,
        ST_RDI     = 4'd6,
        ST_CAP     = 4'd7,
        ST_REL     = 4'd8
    } state_t;

    // CTRL write data: {5'b0, SS, MODE}
    function automatic logic [7:0] ctrl_byte(input logic ss, input logic [1:0] mode);
        logic [7:0] v;
        v = 8'h00;
        v[CTRL_SS_BIT] = ss;
        v[CTRL_MODE_LSB +: 2] = mode;
        return v;
    endfunction

endpackage

// File: rtl/spi_sched_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. The grant output is combinational from the
// request vector and a registered last-served pointer; the pointer only moves
// when the owner releases the bus (i_upd), so a grant is stable for a whole
// transaction.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req[1:0]       request per requester
//   i_upd            pulse: record i_upd_idx as last served
//   i_upd_idx        index of the requester just served
//   o_gnt[1:0]       one-hot pick (0 when no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_idx,
    output logic [1:0] o_gnt
);

    // Reset to "req1 served last" so a simultaneous request favours req0.
    logic r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_upd) begin
            r_last <= i_upd_idx;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        if (&i_req) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;  // zero or one bit set
        end
    end

endmodule

// File: rtl/spi_sched.sv
// -----------------------------------------------------------------------------
// spi_sched
// Transaction sequencer and two-way arbiter in front of an SPI master register
// bus. One requester owns the SPI master from slave-select assert to deassert.
// Per byte: write DATA_OUT, poll STATUS until idle, read DATA_IN, hand the
// byte back to the owner.
//
// Optional build macro: SPI_SCHED_TIMEOUT_EN
//   defined   - abort a byte after POLL_TIMEOUT busy polls, set sticky o_err
//   undefined - poll forever, o_err tied 0
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req[1:0]                transaction request per requester
//   i_mode[3:0]               SPI mode ([1:0] req0, [3:2] req1)
//   o_gnt[1:0]                one-hot grant
//   i_tx_valid/i_tx_last[1:0] tx byte valid / last-byte flag per requester
//   i_tx_data[15:0]           tx byte ([7:0] req0, [15:8] req1)
//   o_tx_ready[1:0]           tx byte accepted (WAIT_TX only)
//   o_rx_valid[1:0]           one-cycle pulse, o_rx_data belongs to requester
//   o_rx_data[7:0]            received byte
//   o_busy                    transaction in progress
//   o_err                     sticky poll timeout
//   o_spi_en/o_spi_wr         SPI master register strobe / direction
//   o_spi_addr[3:0]           SPI master register address
//   o_spi_wdata[7:0]          SPI master write data
//   i_spi_rdata[7:0]          SPI master read data, one cycle after read strobe
// -----------------------------------------------------------------------------
module spi_sched
    import spi_sched_pkg::*;
#(
    parameter int POLL_TIMEOUT = 4096,
    parameter int TO_W         = 13
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req,
    input  logic [3:0]  i_mode,
    output logic [1:0]  o_gnt,
    input  logic [1:0]  i_tx_valid,
    input  logic [15:0] i_tx_data,
    input  logic [1:0]  i_tx_last,
    output logic [1:0]  o_tx_ready,
    output logic [1:0]  o_rx_valid,
    output logic [7:0]  o_rx_data,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_spi_en,
    output logic        o_spi_wr,
    output logic [3:0]  o_spi_addr,
    output logic [7:0]  o_spi_wdata,
    input  logic [7:0]  i_spi_rdata
);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_gnt;
    logic        r_gidx;
    logic        r_busy;
    logic        r_tx_last;
    logic        r_spi_en;
    logic        r_spi_wr;
    logic [3:0]  r_spi_addr;
    logic [7:0]  r_spi_wdata;

    logic [1:0]  w_pick;
    logic        w_gidx;     // owner index valid on the IDLE->SEL edge too
    logic [1:0]  w_mode;
    logic [7:0]  w_tx_byte;
    logic        w_spi_en;
    logic        w_spi_wr;
    logic [3:0]  w_spi_addr;
    logic [7:0]  w_spi_wdata;
    logic        w_busy_bit;

    rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_upd     (r_state == ST_REL),
        .i_upd_idx (r_gidx),
        .o_gnt     (w_pick)
    );

    assign w_gidx     = (r_state == ST_IDLE) ? w_pick[1] : r_gidx;
    assign w_mode     = w_gidx ? i_mode[3:2] : i_mode[1:0];
    assign w_tx_byte  = w_gidx ? i_tx_data[15:8] : i_tx_data[7:0];
    assign w_busy_bit = i_spi_rdata[STATUS_BUSY_BIT];

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] r_poll_cnt;
    logic            r_err;
    logic            w_timeout;
`else
    // Timeout sizing is meaningless without the timeout logic.
    wire w_unused_cfg = (POLL_TIMEOUT > 0) && (TO_W > 0);
`endif

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next state and strobe decode ----------------
    always_comb begin
        w_state_next = r_state;
`ifdef SPI_SCHED_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            ST_IDLE:    if (|i_req) w_state_next = ST_SEL;
            ST_SEL:     w_state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_valid[r_gidx]) begin
                    w_state_next = ST_WR;
                end else if (!i_req[r_gidx]) begin
                    w_state_next = ST_REL;
                end
            end
            ST_WR:      w_state_next = ST_POLL;
            ST_POLL:    w_state_next = ST_CHK;
            ST_CHK: begin
                if (w_busy_bit) begin
`ifdef SPI_SCHED_TIMEOUT_EN
                    // This CHK is busy poll number r_poll_cnt+1.
                    if (r_poll_cnt == TO_W'(POLL_TIMEOUT - 1)) begin
                        w_state_next = ST_REL;
                        w_timeout    = 1'b1;
                    end else begin
                        w_state_next = ST_POLL;
                    end
`else
                    w_state_next = ST_POLL;
`endif
                end else begin
                    w_state_next = ST_RDI;
                end
            end
            ST_RDI:     w_state_next = ST_CAP;
            ST_CAP: begin
                if (r_tx_last || !i_req[r_gidx]) begin
                    w_state_next = ST_REL;
                end else begin
                    w_state_next = ST_WAIT_TX;
                end
            end
            ST_REL:     w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so each strobe
    // is visible exactly during the state that issues it.
    always_comb begin
        w_spi_en    = 1'b0;
        w_spi_wr    = 1'b0;
        w_spi_addr  = 4'd0;
        w_spi_wdata = 8'd0;
        case (w_state_next)
            ST_SEL: begin
                w_spi_en    = 1'b1;
                w_spi_wr    = 1'b1;
                w_spi_addr  = ADDR_CTRL;
                w_spi_wdata = ctrl_byte(1'b1, w_mode);
            end
            ST_WR: begin
                w_spi_en    = 1'b1;
                w_spi_wr    = 1'b1;
                w_spi_addr  = ADDR_DATA_OUT;
                w_spi_wdata = w_tx_byte;
            end
            ST_POLL: begin
                w_spi_en    = 1'b1;
                w_spi_addr  = ADDR_STATUS;
            end
            ST_RDI: begin
                w_spi_en    = 1'b1;
                w_spi_addr  = ADDR_DATA_IN;
            end
            ST_REL: begin
                w_spi_en    = 1'b1;
                w_spi_wr    = 1'b1;
                w_spi_addr  = ADDR_CTRL;
                w_spi_wdata = ctrl_byte(1'b0, w_mode);
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt       <= 2'b00;
            r_gidx      <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_last   <= 1'b0;
            r_spi_en    <= 1'b0;
            r_spi_wr    <= 1'b0;
            r_spi_addr  <= 4'd0;
            r_spi_wdata <= 8'd0;
        end else begin
            r_spi_en    <= w_spi_en;
            r_spi_wr    <= w_spi_wr;
            r_spi_addr  <= w_spi_addr;
            r_spi_wdata <= w_spi_wdata;

            if (w_state_next == ST_IDLE) begin
                r_gnt  <= 2'b00;
                r_busy <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                r_gnt  <= w_pick;
                r_gidx <= w_pick[1];
                r_busy <= 1'b1;
            end

            if (r_state == ST_WAIT_TX && w_state_next == ST_WR) begin
                r_tx_last <= i_tx_last[r_gidx];
            end
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_poll_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_state_next == ST_WR) begin
                r_poll_cnt <= '0;
            end else if (r_state == ST_CHK && w_busy_bit) begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end

            if (w_state_next == ST_SEL) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // ---------------- outputs ----------------
    assign o_gnt       = r_gnt;
    assign o_busy      = r_busy;
    assign o_tx_ready  = (r_state == ST_WAIT_TX) ? r_gnt : 2'b00;
    assign o_rx_valid  = (r_state == ST_CAP) ? r_gnt : 2'b00;
    assign o_rx_data   = (r_state == ST_CAP) ? i_spi_rdata : 8'd0;
    assign o_spi_en    = r_spi_en;
    assign o_spi_wr    = r_spi_wr;
    assign o_spi_addr  = r_spi_addr;
    assign o_spi_wdata = r_spi_wdata;

endmodule

// File: tb/tb_spi_sched.sv
module tb_spi_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [3:0]  mode;
    logic [1:0]  gnt;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [1:0]  tx_last;
    logic [1:0]  tx_ready;
    logic [1:0]  rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        err;
    logic        spi_en;
    logic        spi_wr;
    logic [3:0]  spi_addr;
    logic [7:0]  spi_wdata;
    logic [7:0]  spi_rdata;

    always #5 clk = ~clk;

    spi_sched #(.POLL_TIMEOUT(16), .TO_W(5)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_mode      (mode),
        .o_gnt       (gnt),
        .i_tx_valid  (tx_valid),
        .i_tx_data   (tx_data),
        .i_tx_last   (tx_last),
        .o_tx_ready  (tx_ready),
        .o_rx_valid  (rx_valid),
        .o_rx_data   (rx_data),
        .o_busy      (busy),
        .o_err       (err),
        .o_spi_en    (spi_en),
        .o_spi_wr    (spi_wr),
        .o_spi_addr  (spi_addr),
        .o_spi_wdata (spi_wdata),
        .i_spi_rdata (spi_rdata)
    );

    // ---------------- SPI master model ----------------
    // Busy for 8 cycles after a DATA_OUT write; DATA_IN returns ~last tx byte.
    logic [3:0] s_busy_cnt;
    logic [7:0] s_last_tx;
    logic       s_stuck;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_busy_cnt <= 4'd0;
            s_last_tx  <= 8'd0;
            spi_rdata  <= 8'd0;
        end else begin
            if (spi_en && spi_wr && spi_addr == 4'd1) begin
                s_busy_cnt <= 4'd8;
                s_last_tx  <= spi_wdata;
            end else if (s_busy_cnt != 4'd0) begin
                s_busy_cnt <= s_busy_cnt - 4'd1;
            end
            if (spi_en && !spi_wr) begin
                spi_rdata <= (spi_addr == 4'd0) ? {7'd0, (s_busy_cnt != 4'd0) || s_stuck}
                                                : ~s_last_tx;
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        int         cyc;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
    } strobe_t;

    strobe_t    slog[$];
    logic [9:0] rxlog[$];
    logic [1:0] glog[$];
    logic [1:0] prev_gnt = 2'b00;
    int         bad_ready0 = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_en) begin
            slog.push_back('{cyc, spi_wr, spi_addr, spi_wdata});
            $display("cyc %0d strobe wr=%0b addr=%0d data=0x%02h", cyc, spi_wr, spi_addr, spi_wdata);
        end
        if (|rx_valid) rxlog.push_back({rx_valid, rx_data});
        if (gnt != 2'b00 && prev_gnt == 2'b00) glog.push_back(gnt);
        prev_gnt <= gnt;
        if (tx_ready[0] && gnt[1]) bad_ready0 <= bad_ready0 + 1;
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int idx, input logic [7:0] d, input logic last);
        bit seen;
        seen = 0;
        tx_valid[idx] = 1'b1;
        tx_data[idx*8 +: 8] = d;
        tx_last[idx] = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready[idx]) begin
                seen = 1;
                break;
            end
        end
        chk("tx_accept", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        tx_valid[idx] = 1'b0;
        tx_last[idx]  = 1'b0;
    endtask

    task automatic wait_rx(input int idx, input logic [7:0] exp, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_valid[idx]) begin
                seen = 1;
                break;
            end
        end
        chk(tag, seen ? 32'(rx_data) : 32'hDEAD, 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_grants(input int base, input int n, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (glog.size() - base >= n) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    logic [12:0] exp_seq[16];
    int s0, r0, g0, k, polls;

    initial begin
        rst_n    = 1'b0;
        req      = 2'b00;
        mode     = 4'b0000;
        tx_valid = 2'b00;
        tx_data  = 16'h0000;
        tx_last  = 2'b00;
        s_stuck  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("reset_outputs", {gnt, tx_ready, rx_valid, rx_data, busy, err, spi_en, spi_wr, spi_addr, spi_wdata},
            32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- Test 1: req0, mode 01, bytes A5, 3C(last) ----
        s0 = slog.size();
        r0 = rxlog.size();
        mode = 4'b0001;
        req  = 2'b01;
        offer(0, 8'hA5, 1'b0);
        wait_rx(0, 8'h5A, "t1_rx0");
        offer(0, 8'h3C, 1'b1);
        wait_rx(0, 8'hC3, "t1_rx1");
        req = 2'b00;
        wait_idle("t1_idle");
        chk("t1_gnt_clear", 32'(gnt), 32'd0);
        chk("t1_rx_count", 32'(rxlog.size() - r0), 32'd2);
        exp_seq[0] = {1'b1, 4'd3, 8'h05};
        exp_seq[1] = {1'b1, 4'd1, 8'hA5};
        for (int i = 2; i <= 6; i++) exp_seq[i] = {1'b0, 4'd0, 8'h00};
        exp_seq[7] = {1'b0, 4'd2, 8'h00};
        exp_seq[8] = {1'b1, 4'd1, 8'h3C};
        for (int i = 9; i <= 13; i++) exp_seq[i] = {1'b0, 4'd0, 8'h00};
        exp_seq[14] = {1'b0, 4'd2, 8'h00};
        exp_seq[15] = {1'b1, 4'd3, 8'h01};
        chk("t1_strobe_count", 32'(slog.size() - s0), 32'd16);
        if (slog.size() - s0 == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("t1_strobe%0d", i),
                    32'({slog[s0+i].wr, slog[s0+i].addr, slog[s0+i].wdata}), 32'(exp_seq[i]));
            end
            chk("t1_byte_latency", 32'(slog[s0+7].cyc - slog[s0+1].cyc), 32'd11);
        end

        // ---- Test 2: simultaneous requests after reset alternate ----
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mode     = 4'b0000;
        tx_data  = 16'h2211;
        tx_valid = 2'b11;
        tx_last  = 2'b11;
        g0  = glog.size();
        req = 2'b11;
        wait_grants(g0, 3, "t2_grants_a");
        req = 2'b00;
        wait_idle("t2_idle_a");
        if (glog.size() - g0 >= 3) begin
            chk("t2_grant0", 32'(glog[g0]),   32'b01);
            chk("t2_grant1", 32'(glog[g0+1]), 32'b10);
            chk("t2_grant2", 32'(glog[g0+2]), 32'b01);
        end
        g0  = glog.size();
        req = 2'b11;
        wait_grants(g0, 2, "t2_grants_b");
        req = 2'b00;
        wait_idle("t2_idle_b");
        tx_valid = 2'b00;
        tx_last  = 2'b00;
        if (glog.size() - g0 >= 2) begin
            chk("t2_repeat0", 32'(glog[g0]),   32'b10);
            chk("t2_repeat1", 32'(glog[g0+1]), 32'b01);
        end

        // ---- Test 3: req1 3-byte transaction, req0 waits ----
        mode = 4'b1000;
        g0 = glog.size();
        req[1] = 1'b1;
        wait_grants(g0, 1, "t3_gnt1");
        req[0] = 1'b1;
        k = bad_ready0;
        offer(1, 8'h01, 1'b0);
        wait_rx(1, 8'hFE, "t3_rx0");
        offer(1, 8'h02, 1'b0);
        wait_rx(1, 8'hFD, "t3_rx1");
        offer(1, 8'h03, 1'b1);
        wait_rx(1, 8'hFC, "t3_rx2");
        req[1] = 1'b0;
        wait_grants(g0, 2, "t3_gnt0");
        #1;
        chk("t3_gnt0_onehot", 32'(gnt), 32'b01);
        chk("t3_no_early_ready0", 32'(bad_ready0 - k), 32'd0);
        chk("t3_rel_req1", 32'({slog[$-1].addr, slog[$-1].wdata}), 32'({4'd3, 8'h02}));
        chk("t3_sel_req0", 32'({slog[$].addr, slog[$].wdata}), 32'({4'd3, 8'h04}));
        chk("t3_idle_gap", 32'(slog[$].cyc - slog[$-1].cyc), 32'd2);

        // ---- Test 4: req0 drops in WAIT_TX after one byte ----
        offer(0, 8'h77, 1'b0);
        wait_rx(0, 8'h88, "t4_rx0");
        @(negedge clk);
        chk("t4_wait_tx_ready", 32'(tx_ready), 32'b01);
        k  = cyc;
        s0 = slog.size();
        req[0] = 1'b0;
        wait_idle("t4_idle");
        chk("t4_strobe_count", 32'(slog.size() - s0), 32'd1);
        chk("t4_rel_strobe", 32'({slog[$].wr, slog[$].addr, slog[$].wdata}), 32'({1'b1, 4'd3, 8'h00}));
        chk("t4_rel_cycle", 32'(slog[$].cyc), 32'(k + 1));

`ifdef SPI_SCHED_TIMEOUT_EN
        // ---- Test 5: stuck-busy slave times out ----
        mode    = 4'b0000;
        s_stuck = 1'b1;
        s0 = slog.size();
        r0 = rxlog.size();
        req = 2'b01;
        offer(0, 8'h55, 1'b1);
        req = 2'b00;
        wait_idle("t5_idle");
        polls = 0;
        for (int i = s0; i < slog.size(); i++) begin
            if (!slog[i].wr && slog[i].addr == 4'd0) polls++;
        end
        chk("t5_err_set", 32'(err), 32'd1);
        chk("t5_poll_count", 32'(polls), 32'd16);
        chk("t5_no_rx", 32'(rxlog.size() - r0), 32'd0);
        chk("t5_ss_cleared", 32'({slog[$].wr, slog[$].addr, slog[$].wdata}), 32'({1'b1, 4'd3, 8'h00}));
        s_stuck = 1'b0;
        g0 = glog.size();
        req = 2'b01;
        wait_grants(g0, 1, "t5_regrant");
        chk("t5_err_cleared", 32'(err), 32'd0);
        offer(0, 8'h0F, 1'b1);
        wait_rx(0, 8'hF0, "t5_rx_after");
        req = 2'b00;
        wait_idle("t5_idle2");
`endif

        // ---- Test 6: asynchronous reset during POLL ----
        mode = 4'b0000;
        req  = 2'b01;
        offer(0, 8'h99, 1'b1);
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_en && !spi_wr && spi_addr == 4'd0) begin
                k = 1;
                break;
            end
        end
        chk("t6_reached_poll", 32'(k), 32'd1);
        #2;
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        chk("t6_async_reset", {gnt, tx_ready, rx_valid, rx_data, busy, err, spi_en, spi_wr, spi_addr, spi_wdata},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 2'b01;
        offer(0, 8'h5A, 1'b1);
        wait_rx(0, 8'hA5, "t6_rx_after_reset");
        req = 2'b00;
        wait_idle("t6_idle");
        chk("t6_final_rel", 32'({slog[$].wr, slog[$].addr, slog[$].wdata}), 32'({1'b1, 4'd3, 8'h00}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
